// File: rtl/hwpe_stream_package.sv
// Shared types and helpers for the HWPE stream protocol monitor.
package hwpe_stream_package;

    typedef enum logic [1:0] {
        ERR_VCR       = 2'd0,
        ERR_VDR       = 2'd1,
        ERR_TCDM_MISS = 2'd2,
        ERR_TCDM_SPUR = 2'd3
    } hwpe_monitor_err_e;

    function automatic int unsigned monitor_idx_width(input int unsigned nb_stream,
                                                      input int unsigned nb_tcdm);
        int unsigned nb_max;
        nb_max = (nb_stream > nb_tcdm) ? nb_stream : nb_tcdm;
        return (nb_max > 32'd1) ? $clog2(nb_max) : 32'd1;
    endfunction

endpackage

// File: rtl/hwpe_stream_intf.sv
// Stream and TCDM interfaces with the monitor modports the protocol checker attaches to.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source  (output valid, data, strb, input ready);
    modport sink    (input valid, data, strb, output ready);
    modport monitor (input valid, ready, data, strb);
endinterface

interface hwpe_stream_intf_tcdm ();
    logic        req;
    logic        gnt;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] r_data;
    logic        r_valid;

    modport master  (output req, add, wen, be, data, input gnt, r_data, r_valid);
    modport slave   (input req, add, wen, be, data, output gnt, r_data, r_valid);
    modport monitor (input req, gnt, add, wen, be, data, r_data, r_valid);
endinterface

// File: rtl/hwpe_stream_tcdm_rvalid_tracker.sv
// Follows granted TCDM reads through a fixed-latency pipe and strobes missing or spurious r_valid.
module hwpe_stream_tcdm_rvalid_tracker #(
    parameter int unsigned LATENCY = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_req,
    input  logic i_gnt,
    input  logic i_wen,
    input  logic i_r_valid,
    output logic o_miss,
    output logic o_spur
);
    logic [LATENCY-1:0] r_pipe;
    logic               w_load;
    logic               w_expected;

    assign w_load     = i_req & i_gnt & i_wen;
    assign w_expected = r_pipe[LATENCY-1];

    // Read pipe shifts every cycle; enable only gates the strobes downstream
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pipe <= '0;
        end else if (i_clear) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= LATENCY'({r_pipe, w_load});
        end
    end

    assign o_miss = w_expected & ~i_r_valid;
    assign o_spur = i_r_valid & ~w_expected;
endmodule

// File: rtl/hwpe_stream_protocol_monitor.sv
// Protocol checker for HWPE streams and TCDM ports: sticky error flags, first-error capture,
// a per-violation pulse and saturating handshake counters.
module hwpe_stream_protocol_monitor
    import hwpe_stream_package::*;
#(
    parameter int unsigned  NB_STREAM    = 1,
    parameter int unsigned  DATA_WIDTH   = 32,
    parameter int unsigned  NB_TCDM      = 1,
    parameter int unsigned  TCDM_LATENCY = 1,
    parameter int unsigned  CNT_WIDTH    = 16,
    localparam int unsigned IDX_W        = monitor_idx_width(NB_STREAM, NB_TCDM)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                clear_i,
    input  logic                                enable_i,
    hwpe_stream_intf_stream.monitor             stream_mon [NB_STREAM],
    hwpe_stream_intf_tcdm.monitor               tcdm_mon   [NB_TCDM],
    output logic [NB_STREAM-1:0]                err_stream_vcr_o,
    output logic [NB_STREAM-1:0]                err_stream_vdr_o,
    output logic [NB_TCDM-1:0]                  err_tcdm_miss_o,
    output logic [NB_TCDM-1:0]                  err_tcdm_spur_o,
    output logic                                err_any_o,
    output logic [1:0]                          err_first_code_o,
    output logic [IDX_W-1:0]                    err_first_idx_o,
    output logic                                err_pulse_o,
    output logic [NB_STREAM-1:0][CNT_WIDTH-1:0] hs_count_o
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic [NB_STREAM-1:0]                 w_s_valid, w_s_ready;
    logic [NB_STREAM-1:0][DATA_WIDTH-1:0] w_s_data;
    logic [NB_STREAM-1:0][STRB_W-1:0]     w_s_strb;
    logic [NB_STREAM-1:0]                 r_p_valid, r_p_ready;
    logic [NB_STREAM-1:0][DATA_WIDTH-1:0] r_p_data;
    logic [NB_STREAM-1:0][STRB_W-1:0]     r_p_strb;
    logic [NB_TCDM-1:0]                   w_t_req, w_t_gnt, w_t_wen, w_t_rvalid;
    logic [NB_STREAM-1:0]                 w_vcr, w_vdr;
    logic [NB_TCDM-1:0]                   w_miss, w_spur;
    logic                                 r_armed, w_chk, w_viol_any, w_hit;
    hwpe_monitor_err_e                    w_first_code, r_first_code;
    logic [IDX_W-1:0]                     w_first_idx, r_first_idx;
    logic [NB_STREAM-1:0]                 r_err_vcr, r_err_vdr;
    logic [NB_TCDM-1:0]                   r_err_miss, r_err_spur;
    logic                                 r_err_any, r_pulse;
    logic [NB_STREAM-1:0][CNT_WIDTH-1:0]  r_cnt;

    for (genvar i = 0; i < NB_STREAM; i++) begin : g_stream_in
        assign w_s_valid[i] = stream_mon[i].valid;
        assign w_s_ready[i] = stream_mon[i].ready;
        assign w_s_data[i]  = stream_mon[i].data;
        assign w_s_strb[i]  = stream_mon[i].strb;
    end

    for (genvar j = 0; j < NB_TCDM; j++) begin : g_tcdm_in
        assign w_t_req[j]    = tcdm_mon[j].req;
        assign w_t_gnt[j]    = tcdm_mon[j].gnt;
        assign w_t_wen[j]    = tcdm_mon[j].wen;
        assign w_t_rvalid[j] = tcdm_mon[j].r_valid;
    end

    assign w_chk = r_armed & enable_i;

    if (TCDM_LATENCY > 0) begin : g_tcdm
        logic [NB_TCDM-1:0] w_miss_raw, w_spur_raw;
        for (genvar j = 0; j < NB_TCDM; j++) begin : g_trk
            hwpe_stream_tcdm_rvalid_tracker #(
                .LATENCY (TCDM_LATENCY)
            ) i_tracker (
                .i_clk     (clk_i),
                .i_rst_n   (rst_ni),
                .i_clear   (clear_i),
                .i_req     (w_t_req[j]),
                .i_gnt     (w_t_gnt[j]),
                .i_wen     (w_t_wen[j]),
                .i_r_valid (w_t_rvalid[j]),
                .o_miss    (w_miss_raw[j]),
                .o_spur    (w_spur_raw[j])
            );
        end
        assign w_miss = w_miss_raw & {NB_TCDM{w_chk}};
        assign w_spur = w_spur_raw & {NB_TCDM{w_chk}};
    end else begin : g_no_tcdm
        assign w_miss = '0;
        assign w_spur = '0;
    end

    // Stream violations are judged against last cycle's registered handshake state
    always_comb begin
        w_vcr = '0;
        w_vdr = '0;
        for (int i = 0; i < NB_STREAM; i++) begin
            if (w_chk && r_p_valid[i] && !r_p_ready[i]) begin
                w_vcr[i] = (w_s_data[i] != r_p_data[i]) || (w_s_strb[i] != r_p_strb[i]);
                w_vdr[i] = ~w_s_valid[i];
            end else begin
                w_vcr[i] = 1'b0;
                w_vdr[i] = 1'b0;
            end
        end
    end

    assign w_viol_any = (|w_vcr) | (|w_vdr) | (|w_miss) | (|w_spur);

    // First hit wins: streams before TCDM, low index first, low code first
    always_comb begin
        w_first_code = ERR_VCR;
        w_first_idx  = '0;
        w_hit        = 1'b0;
        for (int i = 0; i < NB_STREAM; i++) begin
            if (!w_hit && w_vcr[i]) begin
                w_first_code = ERR_VCR;
                w_first_idx  = IDX_W'(i);
                w_hit        = 1'b1;
            end else if (!w_hit && w_vdr[i]) begin
                w_first_code = ERR_VDR;
                w_first_idx  = IDX_W'(i);
                w_hit        = 1'b1;
            end else begin
                w_hit = w_hit;
            end
        end
        for (int j = 0; j < NB_TCDM; j++) begin
            if (!w_hit && w_miss[j]) begin
                w_first_code = ERR_TCDM_MISS;
                w_first_idx  = IDX_W'(j);
                w_hit        = 1'b1;
            end else if (!w_hit && w_spur[j]) begin
                w_first_code = ERR_TCDM_SPUR;
                w_first_idx  = IDX_W'(j);
                w_hit        = 1'b1;
            end else begin
                w_hit = w_hit;
            end
        end
    end

    // Handshake history and the armed bit that masks the first cycle after reset/clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_p_valid <= '0;
            r_p_ready <= '0;
            r_p_data  <= '0;
            r_p_strb  <= '0;
            r_armed   <= 1'b0;
        end else if (clear_i) begin
            r_p_valid <= '0;
            r_p_ready <= '0;
            r_p_data  <= '0;
            r_p_strb  <= '0;
            r_armed   <= 1'b0;
        end else begin
            r_p_valid <= w_s_valid;
            r_p_ready <= w_s_ready;
            r_p_data  <= w_s_data;
            r_p_strb  <= w_s_strb;
            r_armed   <= 1'b1;
        end
    end

    // Sticky flags, violation pulse and first-error capture
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_vcr    <= '0;
            r_err_vdr    <= '0;
            r_err_miss   <= '0;
            r_err_spur   <= '0;
            r_err_any    <= 1'b0;
            r_pulse      <= 1'b0;
            r_first_code <= ERR_VCR;
            r_first_idx  <= '0;
        end else if (clear_i) begin
            r_err_vcr    <= '0;
            r_err_vdr    <= '0;
            r_err_miss   <= '0;
            r_err_spur   <= '0;
            r_err_any    <= 1'b0;
            r_pulse      <= 1'b0;
            r_first_code <= ERR_VCR;
            r_first_idx  <= '0;
        end else begin
            r_err_vcr  <= r_err_vcr | w_vcr;
            r_err_vdr  <= r_err_vdr | w_vdr;
            r_err_miss <= r_err_miss | w_miss;
            r_err_spur <= r_err_spur | w_spur;
            r_err_any  <= r_err_any | w_viol_any;
            r_pulse    <= w_viol_any;
            if (!r_err_any && w_viol_any) begin
                r_first_code <= w_first_code;
                r_first_idx  <= w_first_idx;
            end
        end
    end

    // Saturating per-stream handshake counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < NB_STREAM; i++) begin
                if (enable_i && w_s_valid[i] && w_s_ready[i] && (r_cnt[i] != {CNT_WIDTH{1'b1}})) begin
                    r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign err_stream_vcr_o = r_err_vcr;
    assign err_stream_vdr_o = r_err_vdr;
    assign err_tcdm_miss_o  = r_err_miss;
    assign err_tcdm_spur_o  = r_err_spur;
    assign err_any_o        = r_err_any;
    assign err_first_code_o = r_first_code;
    assign err_first_idx_o  = r_first_idx;
    assign err_pulse_o      = r_pulse;
    assign hs_count_o       = r_cnt;
endmodule

// File: doc/hwpe_stream_protocol_monitor.md
Name: hwpe_stream_protocol_monitor

Overview:
Synthesizable, parametrised protocol checker for HWPE stream and TCDM interfaces. It generalises the simulation-only VCR/VDR/r_valid assertions to NB_STREAM stream channels and NB_TCDM TCDM channels, with a configurable TCDM read latency. Violations are reported through sticky error flags, first-error capture and a per-violation pulse, and a saturating handshake counter is kept per stream. It sits alongside any engine or streamer, attached to the monitor modports, and can be kept in silicon for debug.

Parameters:
NB_STREAM, 1, number of monitored stream channels (>=1)
DATA_WIDTH, 32, stream data width; strobe width is DATA_WIDTH/8
NB_TCDM, 1, number of monitored TCDM channels (>=1)
TCDM_LATENCY, 1, cycles from a granted read to r_valid; range 1..8; 0 disables all TCDM checks
CNT_WIDTH, 16, width of each handshake counter
IDX_W (localparam), max(1, $clog2(max(NB_STREAM,NB_TCDM))), width of the channel index

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous soft clear
enable_i  in  1  enables checking and counting
stream_mon  in  NB_STREAM x hwpe_stream_intf_stream.monitor  monitored streams (DATA_WIDTH)
tcdm_mon  in  NB_TCDM x hwpe_stream_intf_tcdm.monitor  monitored TCDM ports
err_stream_vcr_o  out  NB_STREAM  sticky: data/strb changed while stalled
err_stream_vdr_o  out  NB_STREAM  sticky: valid dropped without a handshake
err_tcdm_miss_o  out  NB_TCDM  sticky: r_valid missing at the expected cycle
err_tcdm_spur_o  out  NB_TCDM  sticky: r_valid with no read pending
err_any_o  out  1  OR of all sticky flags
err_first_code_o  out  2  code of the first captured error
err_first_idx_o  out  IDX_W  channel of the first captured error
err_pulse_o  out  1  high one cycle after any violation cycle
hs_count_o  out  NB_STREAM x CNT_WIDTH  saturating handshake counts

Behaviour:
- Reset (rst_ni=0): all outputs, history registers, the armed bit and the TCDM pipelines are 0.
- clear_i=1: same effect as reset at the next edge. clear_i has priority over any violation or handshake in the same cycle.
- History: each clock edge registers valid, ready, data and strb per stream, unconditionally.
- armed: set at the first edge after reset or clear. Checks are evaluated only when armed & enable_i.
- VCR (code 0): past valid & ~past ready & (data != past data or strb != past strb).
- VDR (code 1): past valid & ~valid & ~past ready.
- TCDM tracking, per channel: shift register of length TCDM_LATENCY. Stage 0 loads req & gnt & wen (wen=1 means read). Every cycle it shifts, regardless of enable_i.
- expected = last stage.
- MISS (code 2): expected & ~r_valid.
- SPUR (code 3): r_valid & ~expected.
- Latency: all detection is registered. A flag rises at the edge ending the violating cycle and stays set until clear or reset.
- err_pulse_o: 1 for exactly one cycle after each violating cycle, even if the flag was already set.
- First-error capture: loaded only when no error has been captured since clear.
- Capture priority within one cycle: streams before TCDM; lower index first; within a channel, lower code first.
- hs_count_o[i]: increments on valid & ready while enable_i=1; saturates at all-ones.
- enable_i=0: no new flags, no counting. Existing state is held and history keeps updating.
- TCDM_LATENCY=0: TCDM flags are tied to 0 and no pipeline is generated.

Decomposition:
- hwpe_stream_package: typedef enum logic[1:0] hwpe_monitor_err_e {ERR_VCR=0, ERR_VDR=1, ERR_TCDM_MISS=2, ERR_TCDM_SPUR=3}.
- Sub-module hwpe_stream_tcdm_rvalid_tracker: one per TCDM channel. It holds the latency shift register and produces the miss/spur strobes.

Test Plan:
1. Stream 0: valid held 3 cycles, data 0xDEADBEEF constant, ready on the 3rd cycle -> no flags, hs_count_o[0]=1.
2. Stream 0: valid=1, ready=0, data 0x1 then 0x2 -> err_stream_vcr_o[0]=1 next cycle, first code 0, idx 0, err_pulse_o high one cycle.
3. Stream 0: valid 1->0 with ready=0 throughout -> err_stream_vdr_o[0]=1, err_any_o=1.
4. TCDM_LATENCY=2, granted read at t with r_valid at t+2 -> no error. Same read with r_valid at t+1 instead -> SPUR flag after t+1, MISS flag after t+2, first code 3.
5. NB_STREAM=2: stream 1 VDR and TCDM 0 SPUR in the same cycle -> first idx 1, code 1; both flags set.
6. CNT_WIDTH=4 with 20 handshakes -> hs_count_o=15. Then clear_i asserted together with a VCR violation -> all outputs 0. Then rst_ni pulsed mid-stall -> no false VCR or VDR on the first cycle after release.
